// File: rtl/digitizer_pkg.sv
// Shared constants, state encoding and address helper for the digitizer
// readout path (single_channel buffer -> SPI readout slave).
package digitizer_pkg;

  // Bits per SPI word and per buffer word.
  localparam int WORD_W = 16;
  // Buffer read-address width.
  localparam int ADDR_W = 12;
  // Width of the per-word bit counter (wraps naturally after WORD_W bits).
  localparam int CNT_W  = $clog2(WORD_W);
  // Width of the external word_num port.
  localparam int WNUM_W = 16;

  // Readout FSM state encoding.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    FETCH = S_FETCH,
    SHIFT = S_SHIFT
  } state_t;

  // Next buffer address in a frame: step up to last (inclusive), then wrap to 0.
  // The address is zero-extended so the compare is done at word_num width.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [WNUM_W-1:0] last);
    logic [WNUM_W-1:0] w_addr_ext;
    w_addr_ext = {{(WNUM_W-ADDR_W){1'b0}}, addr};
    if (w_addr_ext < last) begin
      next_addr = addr + 1'b1;
    end else begin
      next_addr = '0;
    end
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous SPI pin, with registered
// single-cycle rise/fall pulses in the sysclk domain.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;
  logic              r_rise;
  logic              r_fall;
  logic              w_sync;

  assign w_sync = r_chain[STAGES-1];

  // Shift the pin through the synchroniser chain; first flop may go metastable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
    end
  end

  // Registered edge detect on the synchronised level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_prev <= w_sync;
      r_rise <= w_sync & ~r_prev;
      r_fall <= ~w_sync & r_prev;
    end
  end

  assign o_sync = w_sync;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/spi_readout_slave.sv
// Sysclk-domain SPI slave (mode 0, MSB first) streaming the single-channel
// sample buffer to the Zynq. Fetches buffer words, serialises them on MISO,
// deserialises MOSI and pulses spi_done after each complete word.
module spi_readout_slave
  import digitizer_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                sysclk,
  input  logic                rst,
  input  logic                spi_sclk,
  input  logic                spi_ss_n,
  input  logic                spi_mosi,
  output logic                spi_miso,
  input  logic [WNUM_W-1:0]   word_num,
  input  logic [WORD_W-1:0]   rd_data,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic                read_request,
  output logic                spi_done,
  output logic [WORD_W-1:0]   rx_word,
  output logic                rx_valid,
  output logic                busy,
  output logic                overrun
);

  localparam int               LAT_W     = $clog2(READ_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_W - 1);

  // Synchronised SPI pins and edge pulses.
  logic w_sclk_sync_unused;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_ss_sync_unused;
  logic w_ss_rise;
  logic w_ss_fall;
  logic w_mosi;
  logic w_mosi_rise_unused;
  logic w_mosi_fall_unused;
  logic w_word_end;

  // FSM state and datapath registers.
  state_t             r_state;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic [WORD_W-1:0]  r_tx_shreg;
  logic [WORD_W-1:0]  r_rx_shreg;
  logic [ADDR_W-1:0]  r_rd_addr;
  logic               r_read_request;
  logic               r_spi_done;
  logic [WORD_W-1:0]  r_rx_word;
  logic               r_rx_valid;
  logic               r_busy;
  logic               r_overrun;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .i_clk   (sysclk),
    .i_rst   (rst),
    .i_async (spi_sclk),
    .o_sync  (w_sclk_sync_unused),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ss (
    .i_clk   (sysclk),
    .i_rst   (rst),
    .i_async (spi_ss_n),
    .o_sync  (w_ss_sync_unused),
    .o_rise  (w_ss_rise),
    .o_fall  (w_ss_fall)
  );

  // MOSI only needs the synchronised level; it is sampled on sclk rise pulses,
  // and since the sclk pulse is one cycle behind its level, the MOSI level at
  // that point was captured close to the pin rising edge.
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .i_clk   (sysclk),
    .i_rst   (rst),
    .i_async (spi_mosi),
    .o_sync  (w_mosi),
    .o_rise  (w_mosi_rise_unused),
    .o_fall  (w_mosi_fall_unused)
  );

  assign w_word_end = (r_bit_cnt == WORD_LAST);

  // Readout FSM: SS edges have priority over everything, then per-state work,
  // then bit counting on sclk rising edges (counted in FETCH too, as overrun).
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_bit_cnt      <= '0;
      r_lat_cnt      <= '0;
      r_tx_shreg     <= '0;
      r_rx_shreg     <= '0;
      r_rd_addr      <= '0;
      r_read_request <= 1'b0;
      r_spi_done     <= 1'b0;
      r_rx_word      <= '0;
      r_rx_valid     <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_read_request <= 1'b0;
      r_spi_done     <= 1'b0;
      r_rx_valid     <= 1'b0;

      if (w_ss_rise) begin
        // Frame abort: partial word is dropped without spi_done.
        r_state   <= IDLE;
        r_bit_cnt <= '0;
        r_lat_cnt <= '0;
        r_rd_addr <= '0;
        r_busy    <= 1'b0;
      end else if (w_ss_fall) begin
        // Frame start: fetch word 0; a coincident sclk edge is ignored.
        r_state        <= FETCH;
        r_bit_cnt      <= '0;
        r_lat_cnt      <= '0;
        r_rd_addr      <= '0;
        r_read_request <= 1'b1;
        r_overrun      <= 1'b0;
        r_busy         <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
          end
          FETCH: begin
            if (r_lat_cnt == LAT_LAST) begin
              r_tx_shreg <= rd_data;
              r_lat_cnt  <= '0;
              r_state    <= SHIFT;
            end else begin
              r_lat_cnt <= r_lat_cnt + 1'b1;
            end
            // Master clocked before the next word was loaded; the stale MSB
            // is what went out on MISO.
            if (w_sclk_rise) begin
              r_overrun <= 1'b1;
            end
          end
          SHIFT: begin
            // No shift on the falling edge that closes a word, so the MSB of
            // the freshly loaded word stays on MISO for the first rising edge.
            if (w_sclk_fall && (r_bit_cnt != '0)) begin
              r_tx_shreg <= {r_tx_shreg[WORD_W-2:0], 1'b0};
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase

        if ((r_state != IDLE) && w_sclk_rise) begin
          r_rx_shreg <= {r_rx_shreg[WORD_W-2:0], w_mosi};
          r_bit_cnt  <= r_bit_cnt + 1'b1;
          if (w_word_end) begin
            r_spi_done     <= 1'b1;
            r_rx_valid     <= 1'b1;
            r_rx_word      <= {r_rx_shreg[WORD_W-2:0], w_mosi};
            r_rd_addr      <= next_addr(r_rd_addr, word_num);
            r_read_request <= 1'b1;
            r_lat_cnt      <= '0;
            r_state        <= FETCH;
          end
        end
      end
    end
  end

  assign spi_miso     = r_busy & r_tx_shreg[WORD_W-1];
  assign rd_addr      = r_rd_addr;
  assign read_request = r_read_request;
  assign spi_done     = r_spi_done;
  assign rx_word      = r_rx_word;
  assign rx_valid     = r_rx_valid;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_spi_readout_slave.sv
// Scoreboard bench for spi_readout_slave: the SPI-master stimulus pushes the
// expected buffer addresses, MISO words and received MOSI words into queues;
// monitors pop and compare whenever the DUT presents read_request/spi_done.
module tb_spi_readout_slave;

  logic        sysclk = 1'b0;
  logic        rst;
  logic        sclk;
  logic        mosi;
  logic        ss_a;
  logic        ss_b;
  logic [15:0] word_num;

  logic        miso_a,  miso_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic [11:0] rd_addr_a, rd_addr_b;
  logic        rreq_a,  rreq_b;
  logic        done_a,  done_b;
  logic [15:0] rx_word_a, rx_word_b;
  logic        rx_valid_a, rx_valid_b;
  logic        busy_a,  busy_b;
  logic        ovr_a,   ovr_b;

  logic [15:0] mem [0:15];
  logic [15:0] pb1, pb2;

  logic [11:0] q_addr [$];
  logic [15:0] q_rx   [$];
  logic [15:0] q_miso [$];

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  always #5 sysclk = ~sysclk;

  // Instance A: default read latency, used for the functional tests.
  spi_readout_slave #(.READ_LATENCY(1), .SYNC_STAGES(2)) dut_a (
    .sysclk(sysclk), .rst(rst), .spi_sclk(sclk), .spi_ss_n(ss_a), .spi_mosi(mosi),
    .spi_miso(miso_a), .word_num(word_num), .rd_data(rd_data_a), .rd_addr(rd_addr_a),
    .read_request(rreq_a), .spi_done(done_a), .rx_word(rx_word_a), .rx_valid(rx_valid_a),
    .busy(busy_a), .overrun(ovr_a)
  );

  // Instance B: slow buffer, used for the overrun test.
  spi_readout_slave #(.READ_LATENCY(3), .SYNC_STAGES(2)) dut_b (
    .sysclk(sysclk), .rst(rst), .spi_sclk(sclk), .spi_ss_n(ss_b), .spi_mosi(mosi),
    .spi_miso(miso_b), .word_num(word_num), .rd_data(rd_data_b), .rd_addr(rd_addr_b),
    .read_request(rreq_b), .spi_done(done_b), .rx_word(rx_word_b), .rx_valid(rx_valid_b),
    .busy(busy_b), .overrun(ovr_b)
  );

  // Buffer models: 1-cycle and 3-cycle read pipelines.
  always @(posedge sysclk) rd_data_a <= mem[rd_addr_a[3:0]];
  always @(posedge sysclk) begin
    pb1       <= mem[rd_addr_b[3:0]];
    pb2       <= pb1;
    rd_data_b <= pb2;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sysclk);
    #2;
  endtask

  // Mode-0 SPI master: MOSI set while sclk low, MISO sampled at the rising edge.
  task automatic spi_xfer(input logic [15:0] tx, input int half, input int nbits,
                          output logic [15:0] rx);
    rx = '0;
    for (int i = 15; i > 15 - nbits; i--) begin
      mosi = tx[i];
      wait_cyc(half);
      rx[i] = miso_a;
      sclk  = 1'b1;
      wait_cyc(half);
      sclk  = 1'b0;
    end
  endtask

  task automatic xfer_word(input logic [15:0] tx, input int half);
    logic [15:0] got;
    logic [15:0] exp;
    spi_xfer(tx, half, 16, got);
    if (q_miso.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL miso_word: got %0h but no word expected", got);
    end else begin
      exp = q_miso.pop_front();
      check("miso_word", got, exp);
    end
  endtask

  // Monitor for instance A: every fetch strobe and every completed word.
  always @(negedge sysclk) begin : mon
    logic [11:0] ea;
    logic [15:0] er;
    if (!rst) begin
      if (rreq_a) begin
        if (q_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_addr: got unexpected read_request at addr %0h, required none", rd_addr_a);
        end else begin
          ea = q_addr.pop_front();
          check("rd_addr", rd_addr_a, ea);
        end
      end
      if (done_a) begin
        done_cnt++;
        check("rx_valid_with_done", rx_valid_a, 1);
        if (q_rx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_word: got unexpected spi_done with rx_word %0h, required none", rx_word_a);
        end else begin
          er = q_rx.pop_front();
          check("rx_word", rx_word_a, er);
        end
      end else if (rx_valid_a) begin
        checks++;
        errors++;
        $display("FAIL rx_valid: got 1 without spi_done, required 0");
      end
    end
  end

  // Time bound for the whole run.
  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] dummy;
    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; ss_a = 1'b1; ss_b = 1'b1; word_num = 16'd0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[0] = 16'hA5C3;
    wait_cyc(4);

    // Reset state.
    check("rst_rd_addr",  rd_addr_a, 0);
    check("rst_rreq",     rreq_a, 0);
    check("rst_done",     done_a, 0);
    check("rst_rx_word",  rx_word_a, 0);
    check("rst_busy",     busy_a, 0);
    check("rst_overrun",  ovr_a, 0);
    check("rst_miso",     miso_a, 0);
    check("rst_busy_b",   busy_b, 0);
    rst = 1'b0;
    wait_cyc(10);

    // Single word with MOSI 0BEE; address wraps back to 0.
    q_addr.push_back(12'd0); q_addr.push_back(12'd0);
    q_miso.push_back(16'hA5C3);
    q_rx.push_back(16'h0BEE);
    ss_a = 1'b0;
    wait_cyc(10);
    check("single_busy", busy_a, 1);
    xfer_word(16'h0BEE, 5);
    wait_cyc(10);
    check("single_done_cnt", done_cnt, 1);
    ss_a = 1'b1;
    wait_cyc(10);
    check("single_busy_end", busy_a, 0);
    check("single_miso_idle", miso_a, 0);

    // Multi-word frame, five words, addresses 0,1,2,3,0,1.
    word_num = 16'd3;
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    q_addr.push_back(12'd0);
    q_addr.push_back(12'd1); q_addr.push_back(12'd2); q_addr.push_back(12'd3);
    q_addr.push_back(12'd0); q_addr.push_back(12'd1);
    q_miso.push_back(16'h1111); q_miso.push_back(16'h2222); q_miso.push_back(16'h3333);
    q_miso.push_back(16'h4444); q_miso.push_back(16'h1111);
    for (int i = 1; i <= 5; i++) q_rx.push_back(16'hC000 + 16'(i));
    ss_a = 1'b0;
    wait_cyc(10);
    for (int i = 1; i <= 5; i++) xfer_word(16'hC000 + 16'(i), 5);
    wait_cyc(10);
    check("multi_done_cnt", done_cnt, 6);
    ss_a = 1'b1;
    wait_cyc(10);

    // Abort after 9 bits, then a clean frame restarts at address 0.
    q_addr.push_back(12'd0);
    ss_a = 1'b0;
    wait_cyc(10);
    spi_xfer(16'hFFFF, 5, 9, dummy);
    ss_a = 1'b1;
    wait_cyc(10);
    check("abort_done_cnt", done_cnt, 6);
    check("abort_busy", busy_a, 0);
    check("abort_rd_addr", rd_addr_a, 0);
    q_addr.push_back(12'd0); q_addr.push_back(12'd1);
    q_miso.push_back(16'h1111);
    q_rx.push_back(16'h1234);
    ss_a = 1'b0;
    wait_cyc(10);
    xfer_word(16'h1234, 5);
    wait_cyc(10);
    check("restart_done_cnt", done_cnt, 7);
    ss_a = 1'b1;
    wait_cyc(10);

    // Overrun on the slow-buffer instance with back-to-back sclk at f_sys/4.
    ss_b = 1'b0;
    wait_cyc(10);
    check("ovr_busy", busy_b, 1);
    spi_xfer(16'h0000, 2, 16, dummy);
    check("ovr_clear_first_word", ovr_b, 0);
    spi_xfer(16'h0000, 2, 4, dummy);
    wait_cyc(6);
    check("ovr_set", ovr_b, 1);
    ss_b = 1'b1;
    wait_cyc(10);
    check("ovr_sticky", ovr_b, 1);
    check("ovr_busy_end", busy_b, 0);
    ss_b = 1'b0;
    wait_cyc(10);
    check("ovr_cleared", ovr_b, 0);
    ss_b = 1'b1;
    wait_cyc(10);

    // Reset mid-frame at bit_cnt=7.
    word_num = 16'd0;
    mem[0] = 16'hFFFF;
    q_addr.push_back(12'd0);
    ss_a = 1'b0;
    wait_cyc(10);
    spi_xfer(16'h0000, 5, 7, dummy);
    check("pre_rst_busy", busy_a, 1);
    check("pre_rst_miso", miso_a, 1);
    rst = 1'b1;
    @(negedge sysclk);
    check("mid_rst_busy",    busy_a, 0);
    check("mid_rst_miso",    miso_a, 0);
    check("mid_rst_rx_word", rx_word_a, 0);
    check("mid_rst_rd_addr", rd_addr_a, 0);
    check("mid_rst_rreq",    rreq_a, 0);
    check("mid_rst_done",    done_a, 0);
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(20);
    check("post_rst_busy_ss_low", busy_a, 0);
    ss_a = 1'b1;
    wait_cyc(10);

    // Fresh frame after reset works normally.
    q_addr.push_back(12'd0); q_addr.push_back(12'd0);
    q_miso.push_back(16'hFFFF);
    q_rx.push_back(16'h5A5A);
    ss_a = 1'b0;
    wait_cyc(10);
    xfer_word(16'h5A5A, 5);
    wait_cyc(10);
    check("post_rst_done_cnt", done_cnt, 8);
    ss_a = 1'b1;
    wait_cyc(10);

    check("q_addr_empty", q_addr.size(), 0);
    check("q_rx_empty",   q_rx.size(), 0);
    check("q_miso_empty", q_miso.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
